sseg_scan_driver: RTL and testbench



---
 rtl/sseg_scan_driver.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits. It scans the anodes one at a time and puts an all-off
// guard gap between digits. The displayed value is double-buffered, so a
// frame is never built from a mix of old and new data.
//
// Optional build macro: SSEG_DP_EN adds a buffered decimal-point mask input
// (dp_mask) and an active-low decimal-point output (dp).
module sseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    neg,
  input  logic                    blank_lz,
  input  logic                    turbo_mode,
  input  logic                    enable,
`ifdef SSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAX_CYCLES = (DRIVE_CYCLES > GUARD_CYCLES) ? DRIVE_CYCLES : GUARD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF   = 7'b111_1111;
  localparam logic [6:0] SEG_MINUS = 7'b011_1111;
  localparam logic [6:0] SEG_TURBO = 7'b100_0000;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Standard active-low hex glyphs, bit6=g .. bit0=a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b100_0000;
      4'h1: g = 7'b111_1001;
      4'h2: g = 7'b010_0100;
      4'h3: g = 7'b011_0000;
      4'h4: g = 7'b001_1001;
      4'h5: g = 7'b001_0010;
      4'h6: g = 7'b000_0010;
      4'h7: g = 7'b111_1000;
      4'h8: g = 7'b000_0000;
      4'h9: g = 7'b001_1000;
      4'hA: g = 7'b000_1000;
      4'hB: g = 7'b000_0011;
      4'hC: g = 7'b100_0110;
      4'hD: g = 7'b010_0001;
      4'hE: g = 7'b000_0110;
      default: g = 7'b000_1110;
    endcase
    return g;
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    frame_start;
  logic                    wrap;

  // Shadow buffer (written by load) and active buffer (what the scan shows).
  logic [4*NUM_DIGITS-1:0] shadow_val, active_val, active_val_d;
  logic                    shadow_neg, active_neg, active_neg_d;
  logic                    shadow_blz, active_blz, active_blz_d;
  logic                    pending;
  logic                    take_shadow;

  logic [3:0]              nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [6:0]              glyph_d;
  logic [6:0]              segs_d;
  logic [NUM_DIGITS-1:0]   an_d;

`ifdef SSEG_DP_EN
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, active_dp_d;
  logic                    dp_d;
`endif

  // State, digit index and cycle counter register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: scan sequencing, digit advance and frame wrap.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + 1'b1;
    frame_start = 1'b0;
    wrap        = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = ST_GUARD;
          idx_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              wrap        = 1'b1;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Active buffer copies the shadow only on frame start with new data waiting.
  always_comb begin
    take_shadow  = frame_start && pending;
    active_val_d = take_shadow ? shadow_val : active_val;
    active_neg_d = take_shadow ? shadow_neg : active_neg;
    active_blz_d = take_shadow ? shadow_blz : active_blz;
`ifdef SSEG_DP_EN
    active_dp_d  = take_shadow ? shadow_dp  : active_dp;
`endif
  end

  // Shadow/active buffers and the pending flag. A load on a frame-start
  // edge leaves pending set, so its data goes into the following frame.
  // NOTE: the buffers are a handful of flops, not a memory, so they get a
  // reset to the cleared state like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_neg <= 1'b0;
      shadow_blz <= 1'b0;
      active_val <= '0;
      active_neg <= 1'b0;
      active_blz <= 1'b0;
      pending    <= 1'b0;
`ifdef SSEG_DP_EN
      shadow_dp  <= '0;
      active_dp  <= '0;
`endif
    end else begin
      active_val <= active_val_d;
      active_neg <= active_neg_d;
      active_blz <= active_blz_d;
`ifdef SSEG_DP_EN
      active_dp  <= active_dp_d;
`endif
      if (load) begin
        shadow_val <= value;
        shadow_neg <= neg;
        shadow_blz <= blank_lz;
`ifdef SSEG_DP_EN
        shadow_dp  <= dp_mask;
`endif
        pending    <= 1'b1;
      end else if (take_shadow) begin
        pending    <= 1'b0;
      end
    end
  end

  // Leading-zero scan from the MSD down. A minus sign takes the MSD out of the scan.
  always_comb begin
    logic above_all_zero;
    above_all_zero = 1'b1;
    lz_blank       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibs[i] = active_val_d[4*i +: 4];
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!(i == NUM_DIGITS - 1 && active_neg_d)) begin
        lz_blank[i]    = active_blz_d && above_all_zero && (nibs[i] == 4'h0) && (i != 0);
        above_all_zero = above_all_zero && (nibs[i] == 4'h0);
      end
    end
  end

  // Glyph for the digit about to be guarded/driven, in priority order.
  always_comb begin
    if (turbo_mode) begin
      glyph_d = SEG_TURBO;
    end else if (active_neg_d && (idx_d == IDX_LAST)) begin
      glyph_d = SEG_MINUS;
    end else if (lz_blank[idx_d]) begin
      glyph_d = SEG_OFF;
    end else begin
      glyph_d = hex_glyph(nibs[idx_d]);
    end
  end

  // Output decode from the next state, so the pins change together with the state.
  always_comb begin
    an_d   = '1;
    segs_d = (state_d == ST_OFF) ? SEG_OFF : glyph_d;
    if (state_d == ST_DRIVE) begin
      an_d[idx_d] = 1'b0;
    end
`ifdef SSEG_DP_EN
    dp_d = !((state_d == ST_DRIVE) && active_dp_d[idx_d] && !turbo_mode);
`endif
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      segs       <= SEG_OFF;
      frame_done <= 1'b0;
`ifdef SSEG_DP_EN
      dp         <= 1'b1;
`endif
    end else begin
      an         <= an_d;
      segs       <= segs_d;
      frame_done <= wrap;
`ifdef SSEG_DP_EN
      dp         <= dp_d;
`endif
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver (NUM_DIGITS=4, DRIVE_CYCLES=4, GUARD_CYCLES=1).
// A frame-position model predicts the pins on every cycle. Directed literal
// checks pin the glyphs and the timing by hand.
module tb_sseg_scan_driver;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int GC    = 1;
  localparam int SLOT  = GC + DC;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] HEX [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic          neg = 1'b0;
  logic          blank_lz = 1'b0;
  logic          turbo_mode = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    dp_mask_in = '0;
  logic [6:0]    segs;
  logic [ND-1:0] an;
  logic          frame_done;
`ifdef SSEG_DP_EN
  logic          dp;
`endif

  int checks = 0;
  int errors = 0;
  logic checking = 1'b0;

  sseg_scan_driver #(.NUM_DIGITS(ND), .DRIVE_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .neg        (neg),
    .blank_lz   (blank_lz),
    .turbo_mode (turbo_mode),
    .enable     (enable),
`ifdef SSEG_DP_EN
    .dp_mask    (dp_mask_in),
    .dp         (dp),
`endif
    .segs       (segs),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The scan is a position 0..FRAME-1 within the frame. Slot = pos / SLOT, and
  // the first GC positions of a slot are the guard gap.
  logic        m_on;
  int          m_pos;
  logic        m_fd;
  logic        m_turbo;
  logic [15:0] m_sh_val, m_act_val;
  logic        m_sh_neg, m_act_neg, m_sh_blz, m_act_blz;
  logic [3:0]  m_sh_dp, m_act_dp;

  task automatic m_apply();
    m_act_val = m_sh_val;
    m_act_neg = m_sh_neg;
    m_act_blz = m_sh_blz;
    m_act_dp  = m_sh_dp;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 0; m_pos = 0; m_fd = 0; m_turbo = 0;
      m_sh_val = '0; m_act_val = '0; m_sh_neg = 0; m_act_neg = 0;
      m_sh_blz = 0; m_act_blz = 0; m_sh_dp = '0; m_act_dp = '0;
    end else begin
      m_fd    = 0;
      m_turbo = turbo_mode;
      if (!enable) begin
        m_on = 0; m_pos = 0;
      end else if (!m_on) begin
        m_on = 1; m_pos = 0; m_apply();
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0) begin
          m_fd = 1; m_apply();
        end
      end
      if (load) begin
        m_sh_val = value; m_sh_neg = neg; m_sh_blz = blank_lz; m_sh_dp = dp_mask_in;
      end
    end
  end

  function automatic logic [6:0] model_glyph(input int d);
    int top;
    int hi;
    if (m_turbo) return 7'h40;
    if (m_act_neg && d == ND - 1) return 7'h3F;
    hi  = m_act_neg ? ND - 2 : ND - 1;
    top = -1;
    for (int i = 0; i <= hi; i++) if (m_act_val[4*i +: 4] != 4'h0) top = i;
    if (m_act_blz && d != 0 && d > top) return 7'h7F;
    return HEX[m_act_val[4*d +: 4]];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [3:0] e_an;
      logic [6:0] e_segs;
      logic       e_dp;
      int         d;
      logic       guard;
      d     = m_pos / SLOT;
      guard = (m_pos % SLOT) < GC;
      e_an  = 4'b1111;
      if (!m_on) begin
        e_segs = 7'h7F;
        e_dp   = 1'b1;
      end else begin
        e_segs = model_glyph(d);
        if (!guard) e_an[d] = 1'b0;
        e_dp = !(!guard && m_act_dp[d] && !m_turbo);
      end
      check("model_an", 32'(an), 32'(e_an));
      check("model_segs", 32'(segs), 32'(e_segs));
      check("model_frame_done", 32'(frame_done), 32'(m_fd));
`ifdef SSEG_DP_EN
      check("model_dp", 32'(dp), 32'(e_dp));
`else
      if (e_dp === 1'bx) check("model_dp_x", 32'(e_dp), 32'd1);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] v, input logic n, input logic b, input logic [3:0] dpm);
    value = v; neg = n; blank_lz = b; dp_mask_in = dpm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) check("timeout_an", 32'(an), 32'(target));
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) check("timeout_frame_done", 32'(frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int period;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_segs", 32'(segs), 32'h7F);
    check("reset_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Scan order with 1234
    do_load(16'h1234, 1'b0, 1'b0, 4'b0000);
    enable = 1'b1;
    @(negedge clk);
    check("first_guard_an", 32'(an), 32'hF);
    check("first_guard_segs", 32'(segs), 32'(7'b001_1001));
    wait_an(4'b1110); check("d0_segs_4", 32'(segs), 32'(7'b001_1001));
    wait_an(4'b1101); check("d1_segs_3", 32'(segs), 32'(7'b011_0000));
    wait_an(4'b1011); check("d2_segs_2", 32'(segs), 32'(7'b010_0100));
    wait_an(4'b0111); check("d3_segs_1", 32'(segs), 32'(7'b111_1001));

    // Frame period
    wait_fd();
    period = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && period < 100) begin
      @(negedge clk);
      period++;
    end
    check("frame_period", 32'(period + 1), 32'd20);

    // Mid-frame load
    wait_an(4'b1101);
    do_load(16'hABCD, 1'b0, 1'b0, 4'b0000);
    wait_an(4'b1011); check("mid_old_d2", 32'(segs), 32'(7'b010_0100));
    wait_an(4'b0111); check("mid_old_d3", 32'(segs), 32'(7'b111_1001));
    wait_an(4'b1110); check("mid_new_d0", 32'(segs), 32'(7'b010_0001));
    wait_an(4'b1101); check("mid_new_d1", 32'(segs), 32'(7'b100_0110));
    wait_an(4'b1011); check("mid_new_d2", 32'(segs), 32'(7'b000_0011));
    wait_an(4'b0111); check("mid_new_d3", 32'(segs), 32'(7'b000_1000));

    // Leading-zero blanking
    do_load(16'h0005, 1'b0, 1'b1, 4'b0000);
    wait_fd();
    wait_an(4'b1110); check("lz5_d0", 32'(segs), 32'(7'b001_0010));
    wait_an(4'b1101); check("lz5_d1", 32'(segs), 32'h7F);
    wait_an(4'b0111); check("lz5_d3", 32'(segs), 32'h7F);
    do_load(16'h0000, 1'b0, 1'b1, 4'b0000);
    wait_fd();
    wait_an(4'b1110); check("lz0_d0", 32'(segs), 32'(7'b100_0000));
    wait_an(4'b1101); check("lz0_d1", 32'(segs), 32'h7F);
    do_load(16'h0012, 1'b1, 1'b1, 4'b0000);
    wait_fd();
    wait_an(4'b1110); check("neg_d0", 32'(segs), 32'(7'b010_0100));
    wait_an(4'b1101); check("neg_d1", 32'(segs), 32'(7'b111_1001));
    wait_an(4'b1011); check("neg_d2", 32'(segs), 32'h7F);
    wait_an(4'b0111); check("neg_d3", 32'(segs), 32'(7'b011_1111));

    // Load on the frame-start edge waits one more frame
    wait_fd();
    repeat (19) @(negedge clk);
    value = 16'h0007; neg = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coinc_fd", 32'(frame_done), 32'd1);
    wait_an(4'b1110); check("coinc_old_d0", 32'(segs), 32'(7'b010_0100));
    wait_fd();
    wait_an(4'b1110); check("coinc_new_d0", 32'(segs), 32'(7'b111_1000));
    wait_an(4'b0111); check("coinc_new_d3", 32'(segs), 32'(7'b100_0000));

    // Multiple loads: last wins
    do_load(16'h1111, 1'b0, 1'b0, 4'b0000);
    do_load(16'h2222, 1'b0, 1'b0, 4'b0000);
    wait_fd();
    wait_an(4'b1110); check("last_load_d0", 32'(segs), 32'(7'b010_0100));

    // Turbo
    turbo_mode = 1'b1;
    wait_an(4'b1101); check("turbo_d1", 32'(segs), 32'(7'b100_0000));
    wait_an(4'b1011); check("turbo_d2", 32'(segs), 32'(7'b100_0000));
    turbo_mode = 1'b0;

    // Enable drop during DRIVE of digit 2, then re-enable
    wait_an(4'b1011);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an", 32'(an), 32'hF);
    check("dis_segs", 32'(segs), 32'h7F);
    check("dis_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen_guard_an", 32'(an), 32'hF);
    @(negedge clk);
    check("reen_d0_an", 32'(an), 32'hE);
    check("reen_d0_segs", 32'(segs), 32'(7'b010_0100));

`ifdef SSEG_DP_EN
    do_load(16'h1234, 1'b0, 1'b0, 4'b0010);
    wait_fd();
    wait_an(4'b1110); check("dp_d0_off", 32'(dp), 32'd1);
    wait_an(4'b1101); check("dp_d1_on", 32'(dp), 32'd0);
    wait_an(4'b1011); check("dp_d2_off", 32'(dp), 32'd1);
`endif

    // Async reset mid-DRIVE
    wait_an(4'b1101);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_segs", 32'(segs), 32'h7F);
    check("async_rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_an(4'b0111); check("post_rst_cleared_d3", 32'(segs), 32'(7'b100_0000));

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
